// File: rtl/mem_stage_ldq.sv
// MEM stage: EX/MEM register plus load align/extend for a variable-latency data SRAM; outputs are combinational off the register.
// Raises stallreq_mem while a load response is outstanding; `define MEM_ALIGN_CHK_EN to enable misaligned-load detection (mem_adel).
module mem_stage_ldq #(
  parameter int STALL_W = 6,
  parameter int STAGE   = 3,
  parameter int PC_W    = 32,
  parameter int HILO_W  = 66,
  parameter bit BIG_END = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               ex_valid,
  input  logic [PC_W-1:0]    ex_pc,
  input  logic [2:0]         ex_ld_op,
  input  logic               ex_rf_we,
  input  logic [4:0]         ex_rf_waddr,
  input  logic [31:0]        ex_result,
  input  logic [HILO_W-1:0]  ex_hilo,
  input  logic [31:0]        data_sram_rdata,
  input  logic               data_sram_rvalid,
  output logic [PC_W+37:0]   mem_to_wb_bus,
  output logic [HILO_W-1:0]  hilo_mem_to_wb_bus,
  output logic               mem_wreg,
  output logic [4:0]         mem_waddr,
  output logic [31:0]        mem_wdata,
  output logic               stallreq_mem,
  output logic               mem_adel
);

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LBU  = 3'b010;
  localparam logic [2:0] LD_LH   = 3'b011;
  localparam logic [2:0] LD_LHU  = 3'b100;
  localparam logic [2:0] LD_LW   = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HELD} state_t;

  logic              valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [2:0]        ld_op_q;
  logic              rf_we_q;
  logic [4:0]        waddr_q;
  logic [31:0]       result_q;
  logic [HILO_W-1:0] hilo_q;
  state_t            state_q;
  logic [31:0]       rbuf_q;
  logic              drop_q;

  logic        stall_unused;
  logic        adv;
  logic        adel;
  logic        is_load;
  logic        pending;
  logic        rv;
  logic [31:0] raw_d;
  logic [1:0]  bsel;
  logic        hsel;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] aligned_d;
  logic [31:0] rf_wdata_d;
  logic        rf_we_d;

  assign stall_unused = ^stall;

  // The register "advances" whenever it does not simply hold its entry (bubble loads count).
  assign adv = flush | ~stall[STAGE] | ~stall[STAGE+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      ld_op_q  <= LD_NONE;
      rf_we_q  <= 1'b0;
      waddr_q  <= '0;
      result_q <= '0;
      hilo_q   <= '0;
    end else if (flush || (stall[STAGE] && !stall[STAGE+1])) begin
      valid_q  <= 1'b0;
      rf_we_q  <= 1'b0;
      ld_op_q  <= LD_NONE;
      hilo_q   <= '0;
    end else if (!stall[STAGE]) begin
      valid_q  <= ex_valid;
      pc_q     <= ex_pc;
      ld_op_q  <= ex_ld_op;
      rf_we_q  <= ex_rf_we;
      waddr_q  <= ex_rf_waddr;
      result_q <= ex_result;
      hilo_q   <= ex_hilo;
    end
  end

`ifdef MEM_ALIGN_CHK_EN
  assign adel = valid_q &&
                ((((ld_op_q == LD_LH) || (ld_op_q == LD_LHU)) && result_q[0]) ||
                 ((ld_op_q == LD_LW) && (result_q[1:0] != 2'b00)));
`else
  assign adel = 1'b0;
`endif

  assign is_load = valid_q && (ld_op_q != LD_NONE) && !adel;
  assign pending = is_load && ((state_q == S_IDLE) || (state_q == S_WAIT));
  // drop_q swallows the response of a request whose entry was squashed.
  assign rv      = data_sram_rvalid && !drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rbuf_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      if (data_sram_rvalid) drop_q <= 1'b0;
      if (pending) begin
        if (rv) begin
          if (adv) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_HELD;
            rbuf_q  <= data_sram_rdata;
          end
        end else if (adv) begin
          state_q <= S_IDLE;
          drop_q  <= 1'b1;
        end else begin
          state_q <= S_WAIT;
        end
      end else if ((state_q == S_HELD) && !adv) begin
        state_q <= S_HELD;
      end else begin
        state_q <= S_IDLE;
      end
    end
  end

  assign raw_d  = (state_q == S_HELD) ? rbuf_q : data_sram_rdata;
  assign bsel   = BIG_END ? ~result_q[1:0] : result_q[1:0];
  assign hsel   = BIG_END ? ~result_q[1] : result_q[1];
  assign byte_v = raw_d[{bsel, 3'b000} +: 8];
  assign half_v = raw_d[{hsel, 4'b0000} +: 16];

  always_comb begin
    aligned_d = raw_d;
    case (ld_op_q)
      LD_LB:   aligned_d = {{24{byte_v[7]}}, byte_v};
      LD_LBU:  aligned_d = {24'h0, byte_v};
      LD_LH:   aligned_d = {{16{half_v[15]}}, half_v};
      LD_LHU:  aligned_d = {16'h0, half_v};
      LD_LW:   aligned_d = raw_d;
      default: aligned_d = raw_d;
    endcase
  end

  assign rf_wdata_d = (ld_op_q != LD_NONE) ? aligned_d : result_q;
  assign rf_we_d    = valid_q && rf_we_q && !adel;

  assign stallreq_mem       = pending && !rv;
  assign mem_to_wb_bus      = {pc_q, rf_we_d, waddr_q, rf_wdata_d};
  assign hilo_mem_to_wb_bus = hilo_q;
  assign mem_wreg           = rf_we_d && !stallreq_mem;
  assign mem_waddr          = waddr_q;
  assign mem_wdata          = rf_wdata_d;
  assign mem_adel           = adel;

endmodule

// File: tb/tb_mem_stage_ldq.sv
// Directed bench for mem_stage_ldq: table of zero-wait load/ALU vectors plus hand sequences for wait, hold, flush and reset.
module tb_mem_stage_ldq;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LBU  = 3'b010;
  localparam logic [2:0] LD_LH   = 3'b011;
  localparam logic [2:0] LD_LHU  = 3'b100;
  localparam logic [2:0] LD_LW   = 3'b101;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  ex_ld_op;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_result;
  logic [65:0] ex_hilo;
  logic [31:0] rdata;
  logic        rvalid;
  logic [69:0] mem_to_wb_bus;
  logic [65:0] hilo_bus;
  logic        mem_wreg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        stallreq_mem;
  logic        mem_adel;

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage_ldq dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .flush              (flush),
    .ex_valid           (ex_valid),
    .ex_pc              (ex_pc),
    .ex_ld_op           (ex_ld_op),
    .ex_rf_we           (ex_rf_we),
    .ex_rf_waddr        (ex_rf_waddr),
    .ex_result          (ex_result),
    .ex_hilo            (ex_hilo),
    .data_sram_rdata    (rdata),
    .data_sram_rvalid   (rvalid),
    .mem_to_wb_bus      (mem_to_wb_bus),
    .hilo_mem_to_wb_bus (hilo_bus),
    .mem_wreg           (mem_wreg),
    .mem_waddr          (mem_waddr),
    .mem_wdata          (mem_wdata),
    .stallreq_mem       (stallreq_mem),
    .mem_adel           (mem_adel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] exp_wd;
    logic        exp_we;
    logic        exp_adel;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [69:0] mkbus(input logic [31:0] pc, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    return {pc, we, wa, wd};
  endfunction

  function automatic logic [65:0] mkhilo(input int i);
    return {32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i), 2'b01};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_ex(input logic v, input logic [2:0] op, input logic [31:0] pc,
                          input logic [31:0] res, input logic we, input logic [4:0] wa,
                          input logic [65:0] h);
    ex_valid    = v;
    ex_ld_op    = op;
    ex_pc       = pc;
    ex_result   = res;
    ex_rf_we    = we;
    ex_rf_waddr = wa;
    ex_hilo     = h;
  endtask

  task automatic idle_ex();
    drive_ex(1'b0, LD_NONE, 32'h0, 32'h0, 1'b0, 5'd0, 66'h0);
  endtask

  initial begin
    vecs[0]  = '{LD_LW,   32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 5'd1,  32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[1]  = '{LD_LB,   32'h0000_0103, 32'h80FF_1234, 1'b1, 5'd2,  32'hFFFF_FF80, 1'b1, 1'b0};
    vecs[2]  = '{LD_LBU,  32'h0000_0103, 32'h80FF_1234, 1'b1, 5'd3,  32'h0000_0080, 1'b1, 1'b0};
    vecs[3]  = '{LD_LHU,  32'h0000_0102, 32'h80FF_1234, 1'b1, 5'd4,  32'h0000_80FF, 1'b1, 1'b0};
    vecs[4]  = '{LD_LH,   32'h0000_0102, 32'h80FF_1234, 1'b1, 5'd5,  32'hFFFF_80FF, 1'b1, 1'b0};
    vecs[5]  = '{LD_LB,   32'h0000_0101, 32'h80FF_1234, 1'b1, 5'd6,  32'h0000_0012, 1'b1, 1'b0};
    vecs[6]  = '{LD_LBU,  32'h0000_0100, 32'h80FF_1234, 1'b1, 5'd7,  32'h0000_0034, 1'b1, 1'b0};
    vecs[7]  = '{LD_LH,   32'h0000_0100, 32'h1234_8001, 1'b1, 5'd8,  32'hFFFF_8001, 1'b1, 1'b0};
    vecs[8]  = '{LD_NONE, 32'hCAFE_0001, 32'hFFFF_FFFF, 1'b1, 5'd9,  32'hCAFE_0001, 1'b1, 1'b0};
    vecs[9]  = '{LD_LB,   32'h0000_0102, 32'h80FF_1234, 1'b1, 5'd10, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[10] = '{LD_NONE, 32'h0000_0055, 32'h0000_0000, 1'b0, 5'd11, 32'h0000_0055, 1'b0, 1'b0};
`ifdef MEM_ALIGN_CHK_EN
    vecs[11] = '{LD_LW,   32'h0000_0102, 32'h1122_3344, 1'b1, 5'd12, 32'h1122_3344, 1'b0, 1'b1};
    vecs[12] = '{LD_LHU,  32'h0000_0101, 32'hA1B2_C3D4, 1'b1, 5'd13, 32'h0000_C3D4, 1'b0, 1'b1};
`else
    vecs[11] = '{LD_LW,   32'h0000_0102, 32'h1122_3344, 1'b1, 5'd12, 32'h1122_3344, 1'b1, 1'b0};
    vecs[12] = '{LD_LHU,  32'h0000_0101, 32'hA1B2_C3D4, 1'b1, 5'd13, 32'h0000_C3D4, 1'b1, 1'b0};
`endif

    rst = 1'b1; flush = 1'b0; stall = 6'b0; rdata = 32'h0; rvalid = 1'b0;
    idle_ex();
    step();
    step();
    sample();
    chk("rst_bus",      128'(mem_to_wb_bus), 128'(70'h0));
    chk("rst_hilo",     128'(hilo_bus),      128'(66'h0));
    chk("rst_stallreq", 128'(stallreq_mem),  128'(1'b0));
    chk("rst_wreg",     128'(mem_wreg),      128'(1'b0));
    chk("rst_waddr",    128'(mem_waddr),     128'(5'd0));
    chk("rst_wdata",    128'(mem_wdata),     128'(32'h0));
    chk("rst_adel",     128'(mem_adel),      128'(1'b0));
    rst = 1'b0;
    step();

    // Zero-wait vectors: entry captured on one edge, response in the following cycle.
    for (int i = 0; i < 13; i++) begin
      rvalid = 1'b0;
      drive_ex(1'b1, vecs[i].op, 32'h1000 + 32'(i * 4), vecs[i].addr, vecs[i].we, vecs[i].wa, mkhilo(i));
      step();
      idle_ex();
      rdata  = vecs[i].rdata;
      rvalid = 1'b1;
      sample();
      chk($sformatf("vec%0d_bus", i), 128'(mem_to_wb_bus),
          128'(mkbus(32'h1000 + 32'(i * 4), vecs[i].exp_we, vecs[i].wa, vecs[i].exp_wd)));
      chk($sformatf("vec%0d_stallreq", i), 128'(stallreq_mem), 128'(1'b0));
      chk($sformatf("vec%0d_wreg", i),     128'(mem_wreg),     128'(vecs[i].exp_we));
      chk($sformatf("vec%0d_hilo", i),     128'(hilo_bus),     128'(mkhilo(i)));
      chk($sformatf("vec%0d_adel", i),     128'(mem_adel),     128'(vecs[i].exp_adel));
      step();
    end
    rvalid = 1'b0;

    // Hold versus bubble on the input register.
    drive_ex(1'b1, LD_NONE, 32'h2000, 32'h1111_2222, 1'b1, 5'd3, mkhilo(20));
    step();
    drive_ex(1'b1, LD_NONE, 32'h2004, 32'h3333_4444, 1'b1, 5'd4, mkhilo(21));
    stall = 6'b111111;
    sample();
    chk("hold_pre_bus", 128'(mem_to_wb_bus), 128'(mkbus(32'h2000, 1'b1, 5'd3, 32'h1111_2222)));
    step();
    sample();
    chk("hold_bus",  128'(mem_to_wb_bus), 128'(mkbus(32'h2000, 1'b1, 5'd3, 32'h1111_2222)));
    chk("hold_hilo", 128'(hilo_bus),      128'(mkhilo(20)));
    stall = 6'b001111;
    step();
    sample();
    chk("bubble_we",   128'(mem_to_wb_bus[37]), 128'(1'b0));
    chk("bubble_hilo", 128'(hilo_bus),          128'(66'h0));
    chk("bubble_wreg", 128'(mem_wreg),          128'(1'b0));
    stall = 6'b0;
    step();
    sample();
    chk("resume_bus", 128'(mem_to_wb_bus), 128'(mkbus(32'h2004, 1'b1, 5'd4, 32'h3333_4444)));
    idle_ex();
    step();

    // lw with three wait cycles.
    drive_ex(1'b1, LD_LW, 32'h3000, 32'h0000_0200, 1'b1, 5'd9, mkhilo(30));
    step();
    idle_ex();
    stall = 6'b111111;
    rdata = 32'hFFFF_0000;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk($sformatf("wait%0d_stallreq", c), 128'(stallreq_mem), 128'(1'b1));
      chk($sformatf("wait%0d_wreg", c),     128'(mem_wreg),     128'(1'b0));
      chk($sformatf("wait%0d_waddr", c),    128'(mem_waddr),    128'(5'd9));
      step();
    end
    rdata = 32'h0BAD_F00D; rvalid = 1'b1; stall = 6'b0;
    sample();
    chk("rel_stallreq", 128'(stallreq_mem),  128'(1'b0));
    chk("rel_bus",      128'(mem_to_wb_bus), 128'(mkbus(32'h3000, 1'b1, 5'd9, 32'h0BAD_F00D)));
    chk("rel_wreg",     128'(mem_wreg),      128'(1'b1));
    step();
    rvalid = 1'b0;

    // Response arrives while the stage is stopped for two cycles: captured word must survive.
    drive_ex(1'b1, LD_LW, 32'h3100, 32'h0000_0300, 1'b1, 5'd10, mkhilo(31));
    step();
    idle_ex();
    rdata = 32'h5555_AAAA; rvalid = 1'b1; stall = 6'b111111;
    sample();
    chk("held_rv_stallreq", 128'(stallreq_mem), 128'(1'b0));
    chk("held_rv_wdata",    128'(mem_wdata),    128'(32'h5555_AAAA));
    step();
    rvalid = 1'b0; rdata = 32'hFFFF_FFFF;
    sample();
    chk("held_wdata",    128'(mem_wdata),    128'(32'h5555_AAAA));
    chk("held_stallreq", 128'(stallreq_mem), 128'(1'b0));
    step();
    rdata = 32'h1234_5678; rvalid = 1'b1; stall = 6'b0;
    sample();
    chk("held_rel_bus",  128'(mem_to_wb_bus), 128'(mkbus(32'h3100, 1'b1, 5'd10, 32'h5555_AAAA)));
    chk("held_rel_wreg", 128'(mem_wreg),      128'(1'b1));
    step();
    rvalid = 1'b0;
    sample();
    chk("post_held_we", 128'(mem_to_wb_bus[37]), 128'(1'b0));

    // Flush during WAIT; the late response must be swallowed.
    drive_ex(1'b1, LD_LW, 32'h3200, 32'h0000_0400, 1'b1, 5'd7, mkhilo(32));
    step();
    idle_ex();
    stall = 6'b111111;
    sample();
    chk("fl_pend_stallreq", 128'(stallreq_mem), 128'(1'b1));
    step();
    flush = 1'b1;
    sample();
    chk("fl_during_stallreq", 128'(stallreq_mem), 128'(1'b1));
    step();
    flush = 1'b0; stall = 6'b0;
    sample();
    chk("fl_after_stallreq", 128'(stallreq_mem),      128'(1'b0));
    chk("fl_after_we",       128'(mem_to_wb_bus[37]), 128'(1'b0));
    chk("fl_after_wreg",     128'(mem_wreg),          128'(1'b0));
    chk("fl_after_hilo",     128'(hilo_bus),          128'(66'h0));
    step();
    rdata = 32'hBBBB_BBBB; rvalid = 1'b1;
    sample();
    chk("fl_late_stallreq", 128'(stallreq_mem), 128'(1'b0));
    chk("fl_late_wreg",     128'(mem_wreg),     128'(1'b0));
    step();
    rvalid = 1'b0;
    drive_ex(1'b1, LD_LW, 32'h3300, 32'h0000_0500, 1'b1, 5'd8, mkhilo(33));
    step();
    idle_ex();
    rdata = 32'h0000_5A5A; rvalid = 1'b1;
    sample();
    chk("post_fl_bus",      128'(mem_to_wb_bus), 128'(mkbus(32'h3300, 1'b1, 5'd8, 32'h0000_5A5A)));
    chk("post_fl_stallreq", 128'(stallreq_mem),  128'(1'b0));
    step();
    rvalid = 1'b0;

    // Reset during WAIT.
    drive_ex(1'b1, LD_LW, 32'h3400, 32'h0000_0600, 1'b1, 5'd11, mkhilo(34));
    step();
    idle_ex();
    stall = 6'b111111;
    sample();
    chk("rs_pend_stallreq", 128'(stallreq_mem), 128'(1'b1));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; stall = 6'b0;
    sample();
    chk("rs_stallreq", 128'(stallreq_mem),  128'(1'b0));
    chk("rs_bus",      128'(mem_to_wb_bus), 128'(70'h0));
    chk("rs_hilo",     128'(hilo_bus),      128'(66'h0));
    step();
    rdata = 32'hCCCC_CCCC; rvalid = 1'b1;
    sample();
    chk("rs_late_stallreq", 128'(stallreq_mem), 128'(1'b0));
    chk("rs_late_wreg",     128'(mem_wreg),     128'(1'b0));
    chk("rs_late_wdata",    128'(mem_wdata),    128'(32'h0));
    step();
    rvalid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
